fsqrt_iter_ctrl: RTL
====================

// Module: fsqrt_iter_ctrl
// PURPOSE
//  Multi-cycle sequencer computing IEEE-754 single-precision sqrt(A) with one shared
//  combinational divider, adder and multiplier (FloatingDivision/Addition/Multiplication)
//  instead of three unrolled Newton stages. Holds x_k in a register; one Newton step per cycle.
//  Sits between the cosine-similarity norm accumulator (producer) and the final divide (consumer).
// PARAMETERS
//  XLEN   32            operand width; only 32 is supported
//  ITERS  3             Newton iterations, 1..7
//  X0     32'h3f5a827a  initial guess x0 for mantissa in [0.5,1)
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     operand A presented
//  in_ready   out  1     controller can accept A (high only in IDLE)
//  in_a       in   32    operand A
//  out_valid  out  1     result available; held until out_ready
//  out_ready  in   1     consumer accepts result
//  result     out  32    sqrt(A)
//  exception  out  1     qualified by out_valid: negative nonzero or NaN input
//  underflow  out  1     qualified by out_valid: denormal input flushed
//  overflow   out  1     constant 0 (sqrt cannot overflow)
//  div_a/div_b out 32    shared divider operands;  div_res in 32  quotient
//  add_a/add_b out 32    shared adder operands;    add_res in 32  sum
//  mul_a/mul_b out 32    shared multiplier operands; mul_res in 32 product
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, x=0, iter count=0,
//   all shared-unit operand outputs=0. Reset mid-operation aborts; no output is produced.
//  Decode on accept (in_valid&in_ready): S=A[31], E=A[30:23], M=A[22:0].
//   m_reg={1'b0,8'd126,M}; e=E-127 (signed 9b); half=e>>>1 (floor); odd=e[0].
//  Special cases (IDLE->DONE, out_valid at accept+1):
//   E==0,M==0: result=A (signed zero kept).  E==0,M!=0: result=+0, underflow=1.
//   E==255,M==0,S==0: result=A (+inf).  NaN, or S==1 and nonzero: result=32'h7FC00000, exception=1.
//  Normal path: IDLE -> ITER -> SCALE -> ODD -> DONE.
//   ITER (ITERS cycles): div_a=m_reg, div_b=x, add_a=div_res, add_b=x;
//    x <= {add_res[31], add_res[30:23]-1, add_res[22:0]} (halve); x starts at X0; counter k++.
//   SCALE (1 cycle): mul_a=x, mul_b=32'h3fb504f3; s <= mul_res with exponent field += half (8b wrap).
//   ODD (1 cycle): mul_a=s, mul_b=32'h3fb504f3; result <= odd ? mul_res : s.
//   DONE: out_valid=1; result and flags stable until out_ready; on out_valid&out_ready -> IDLE.
//  Latency: accept at cycle t -> out_valid at t+ITERS+3 (normal), t+1 (special).
//  Throughput: one operation in flight; in_ready=0 outside IDLE; no overlap of DONE and next accept.
//  Operand outputs in IDLE/DONE are 0. Shared-unit results are sampled in the same cycle (combinational).
//  in_a sampled only on the accept edge; changes to in_a afterwards are ignored.
// TESTING
//  1. A=32'h40800000 (4.0) -> result 32'h40000000, latency ITERS+3, flags 0.
//  2. A=32'h40000000 (2.0) -> 32'h3FB504F3 +/-1 ulp (odd-exponent path exercised).
//  3. A=32'h3E800000 (0.25) -> 32'h3F000000; A=32'h3F000000 (0.5) -> 32'h3F3504F3 +/-1 ulp.
//  4. A=32'hBF800000 (-1.0) -> 32'h7FC00000, exception=1 at t+1; A=32'h80000000 -> 32'h80000000, flags 0.
//  5. out_ready low 10 cycles in DONE -> result/out_valid stable, in_ready=0; accept of next A only after handshake.
//  6. rst_n low mid-ITER -> out_valid=0, in_ready=1 immediately; next A=4.0 returns 32'h40000000.

Source files
------------

// File: rtl/fsqrt_iter_ctrl.sv
// fsqrt_iter_ctrl: iterative IEEE-754 single-precision square root sequencer.
// One Newton step x <- (m/x + x)/2 per cycle on the mantissa, using one shared
// external divider, adder and multiplier. The result is then rescaled by sqrt(2)
// and the halved exponent.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_a      operand handshake (in_ready high only when idle)
//   out_valid/out_ready/result  result handshake, result held until accepted
//   exception/underflow         NaN-or-negative input / denormal input flushed
//   overflow                    always 0
//   div_*, add_*, mul_*         shared floating-point unit operands and results
module fsqrt_iter_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 3,
  parameter logic [31:0] X0    = 32'h3f5a827a
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            exception,
  output logic            underflow,
  output logic            overflow,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic [XLEN-1:0] div_res,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  input  logic [XLEN-1:0] add_res,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic [XLEN-1:0] mul_res
);

  localparam int unsigned KW     = 3;
  localparam logic [KW-1:0] K_LAST = KW'(ITERS - 1);
  localparam logic [31:0] SQRT2  = 32'h3fb504f3;
  localparam logic [31:0] QNAN   = 32'h7fc00000;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ITER  = 3'd1;
  localparam logic [2:0] SCALE = 3'd2;
  localparam logic [2:0] ODD   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [XLEN-1:0] m_reg;
  logic [XLEN-1:0] x;
  logic [XLEN-1:0] s;
  logic [7:0]      half;
  logic            odd;
  logic [KW-1:0]   k;

  // Operand decode, only meaningful on the accept edge
  logic            accept;
  logic            sgn;
  logic [7:0]      exp_f;
  logic [22:0]     man_f;
  logic signed [8:0] e_s;
  logic            is_zero;
  logic            is_denorm;
  logic            is_pinf;
  logic            is_bad;
  logic            is_special;
  logic [XLEN-1:0] spec_res;
  logic            spec_exc;
  logic            spec_unf;

  assign accept    = in_valid & in_ready;
  assign sgn       = in_a[31];
  assign exp_f     = in_a[30:23];
  assign man_f     = in_a[22:0];
  assign e_s       = $signed({1'b0, exp_f}) - 9'sd127;
  assign is_zero   = (exp_f == 8'd0) && (man_f == 23'd0);
  assign is_denorm = (exp_f == 8'd0) && (man_f != 23'd0);
  assign is_pinf   = (exp_f == 8'hff) && (man_f == 23'd0) && !sgn;
  // Negative denormals are flushed first, so only nonzero-exponent negatives trap
  assign is_bad    = ((exp_f == 8'hff) && (man_f != 23'd0)) || (sgn && (exp_f != 8'd0));
  assign is_special = (exp_f == 8'd0) || is_pinf || is_bad;

  // Result and flags for inputs that bypass the iteration
  always_comb begin
    spec_res = '0;
    spec_exc = 1'b0;
    spec_unf = 1'b0;
    if (is_denorm) begin
      spec_unf = 1'b1;
    end else if (is_zero || is_pinf) begin
      spec_res = in_a;
    end else if (is_bad) begin
      spec_res = QNAN;
      spec_exc = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_special ? DONE : ITER;
      ITER:    if (k == K_LAST) state_nxt = SCALE;
      SCALE:   state_nxt = ODD;
      ODD:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shared-unit operands decoded from registered state; zero when not in use
  always_comb begin
    div_a = '0;
    div_b = '0;
    add_b = '0;
    mul_a = '0;
    mul_b = '0;
    case (state)
      ITER: begin
        div_a = m_reg;
        div_b = x;
        add_b = x;
      end
      SCALE: begin
        mul_a = x;
        mul_b = SQRT2;
      end
      ODD: begin
        mul_a = s;
        mul_b = SQRT2;
      end
      default: ;
    endcase
  end

  // Quotient forwards straight into the adder within the same cycle
  assign add_a = (state == ITER) ? div_res : '0;

  assign overflow = 1'b0;

  // Datapath and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      exception <= 1'b0;
      underflow <= 1'b0;
      m_reg     <= '0;
      x         <= '0;
      s         <= '0;
      half      <= '0;
      odd       <= 1'b0;
      k         <= '0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            m_reg     <= {1'b0, 8'd126, man_f};
            half      <= 8'(e_s >>> 1);
            odd       <= e_s[0];
            x         <= X0;
            k         <= '0;
            exception <= spec_exc;
            underflow <= spec_unf;
            if (is_special) result <= spec_res;
          end
        end
        ITER: begin
          // Halve the sum by decrementing its exponent
          x <= {add_res[31], add_res[30:23] - 8'd1, add_res[22:0]};
          k <= k + KW'(1);
        end
        SCALE: s <= {mul_res[31], mul_res[30:23] + half, mul_res[22:0]};
        ODD:   result <= odd ? mul_res : s;
        default: ;
      endcase
    end
  end

endmodule
